// File: rtl/seg7_pkg.sv
// seg7_pkg: scan state type, active-high segment constants and the BCD decode
// function shared by the seven-segment scan driver and its decoder.
`default_nettype none

package seg7_pkg;

   typedef enum logic [0:0] {
      SCAN_ONES = 1'b0,
      SCAN_TENS = 1'b1
   } scan_state_t;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-high seven-segment decoder;
// codes 10-15 show a dash.
`default_nettype none

module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = bcd_to_seg(bcd);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit multiplexed seven-segment driver with per-slot
// guard interval, frame-atomic digit capture and optional leading-zero blanking.
`default_nettype none

module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] dig_ones,
   input  logic [3:0] dig_tens,
   input  logic       blank_lead_zero,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_start
);

   localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [CW:0]   GUARD   = (CW + 1)'(GUARD_CYCLES);
   localparam logic          POL     = (ACTIVE_LOW != 0);

   scan_state_t   state;
   scan_state_t   state_next;
   logic [CW-1:0] cnt;
   logic [3:0]    sh_ones;
   logic [3:0]    sh_tens;

   logic       slot_end;
   logic       in_guard;
   logic       capture;
   logic       tens_blank;
   logic [3:0] dig_sel;
   logic [6:0] seg_dec;
   logic [6:0] seg_next;
   logic [1:0] an_next;

   assign slot_end   = (cnt == CNT_MAX);
   assign in_guard   = ({1'b0, cnt} < GUARD);
   assign capture    = (state == SCAN_TENS) && slot_end;
   assign tens_blank = blank_lead_zero && (sh_tens == 4'd0);
   assign dig_sel    = (state == SCAN_TENS) ? sh_tens : sh_ones;

   bcd_to_seg7 u_dec (
      .bcd (dig_sel),
      .seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SCAN_ONES;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (slot_end) begin
         state_next = (state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
      end
   end

   // Active-high intent; polarity is applied at the output register.
   always_comb begin
      seg_next = SEG_OFF;
      an_next  = 2'b00;
      if (!in_guard) begin
         if (state == SCAN_ONES) begin
            an_next  = 2'b01;
            seg_next = seg_dec;
         end else if (!tens_blank) begin
            an_next  = 2'b10;
            seg_next = seg_dec;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         sh_ones <= 4'd0;
         sh_tens <= 4'd0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (capture) begin
            sh_ones <= dig_ones;
            sh_tens <= dig_tens;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg         <= SEG_OFF ^ {7{POL}};
         an          <= 2'b00 ^ {2{POL}};
         frame_start <= 1'b0;
      end else begin
         seg         <= seg_next ^ {7{POL}};
         an          <= an_next ^ {2{POL}};
         frame_start <= capture;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed table-driven bench for seg7_scan_driver with
// REFRESH_DIV=8, GUARD_CYCLES=2, ACTIVE_LOW=1.
`default_nettype none

module tb_seg7_scan_driver;

   localparam int RD = 8;
   localparam int GC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] dig_ones = 4'd0;
   logic [3:0] dig_tens = 4'd0;
   logic       blank_lead_zero = 1'b0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_start;

   int checks = 0;
   int failures = 0;
   logic mon_en = 1'b0;

   seg7_scan_driver #(
      .REFRESH_DIV  (RD),
      .GUARD_CYCLES (GC),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .dig_ones        (dig_ones),
      .dig_tens        (dig_tens),
      .blank_lead_zero (blank_lead_zero),
      .seg             (seg),
      .an              (an),
      .frame_start     (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       blank;
      logic [6:0] ones_seg;
      logic [6:0] tens_seg;
      logic [1:0] tens_an;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Both anodes low (active) at once must never happen.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (an === 2'b00) begin
            failures++;
            $display("FAIL an_overlap: got %b expected not 00 at %0t", an, $time);
         end
      end
   end

   task automatic wait_fs();
      bit seen = 1'b0;
      for (int i = 0; i < 4 * RD; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL frame_start_timeout: got none expected pulse within %0d cycles", 4 * RD);
      end
   endtask

   // Checks the 2*RD cycles following a capture (or reset release).
   task automatic check_frame(input logic [6:0] ones_seg, input logic [6:0] tens_seg,
                              input logic [1:0] tens_an, input int chg_at,
                              input logic [3:0] chg_tens, input logic [3:0] chg_ones);
      for (int k = 1; k <= 2 * RD; k++) begin
         int pos;
         logic [6:0] es;
         logic [1:0] ea;
         bit chk_seg;
         @(negedge clk);
         pos = (k - 1) % RD;
         chk_seg = 1'b1;
         if (pos < GC) begin
            ea = 2'b11;
            es = 7'h7F;
         end else if (k <= RD) begin
            ea = 2'b10;
            es = ones_seg;
         end else begin
            ea = tens_an;
            es = tens_seg;
            chk_seg = (tens_an != 2'b11);
         end
         chk("an", {6'd0, an}, {6'd0, ea});
         if (chk_seg) chk("seg", {1'b0, seg}, {1'b0, es});
         chk("frame_start", {7'd0, frame_start}, {7'd0, (k == 2 * RD)});
         if (chg_at == k) begin
            dig_tens = chg_tens;
            dig_ones = chg_ones;
         end
      end
   endtask

   initial begin
      vecs[0] = '{tens: 4'd7,  ones: 4'd3,  blank: 1'b0, ones_seg: 7'b0110000, tens_seg: 7'b1111000, tens_an: 2'b01};
      vecs[1] = '{tens: 4'd0,  ones: 4'd5,  blank: 1'b1, ones_seg: 7'b0010010, tens_seg: 7'b1000000, tens_an: 2'b11};
      vecs[2] = '{tens: 4'd0,  ones: 4'd5,  blank: 1'b0, ones_seg: 7'b0010010, tens_seg: 7'b1000000, tens_an: 2'b01};
      vecs[3] = '{tens: 4'd0,  ones: 4'hC,  blank: 1'b0, ones_seg: 7'b0111111, tens_seg: 7'b1000000, tens_an: 2'b01};
      vecs[4] = '{tens: 4'd9,  ones: 4'd8,  blank: 1'b1, ones_seg: 7'b0000000, tens_seg: 7'b0010000, tens_an: 2'b01};
      vecs[5] = '{tens: 4'hF,  ones: 4'd0,  blank: 1'b1, ones_seg: 7'b1000000, tens_seg: 7'b0111111, tens_an: 2'b01};

      // Reset hold: three cycles of inactive outputs.
      reset = 1'b1;
      dig_tens = 4'd7;
      dig_ones = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mon_en = 1'b1;
         chk("rst_seg", {1'b0, seg}, 8'h7F);
         chk("rst_an", {6'd0, an}, 8'h03);
         chk("rst_fs", {7'd0, frame_start}, 8'h00);
      end
      reset = 1'b0;
      // Shadows are zero until the first capture at 2*RD cycles.
      check_frame(7'h40, 7'h40, 2'b01, 0, 4'd0, 4'd0);

      foreach (vecs[i]) begin
         dig_tens = vecs[i].tens;
         dig_ones = vecs[i].ones;
         blank_lead_zero = vecs[i].blank;
         wait_fs();
         check_frame(vecs[i].ones_seg, vecs[i].tens_seg, vecs[i].tens_an, 0, 4'd0, 4'd0);
      end

      // Tear-free capture: 39 -> 40 changed during the ones slot.
      blank_lead_zero = 1'b0;
      dig_tens = 4'd3;
      dig_ones = 4'd9;
      wait_fs();
      check_frame(7'b0010000, 7'b0110000, 2'b01, 4, 4'd4, 4'd0);
      check_frame(7'b1000000, 7'b0011001, 2'b01, 0, 4'd0, 4'd0);

      // Mid-scan reset at cnt=5 of the tens slot.
      dig_tens = 4'd7;
      dig_ones = 4'd3;
      wait_fs();
      repeat (RD + 5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_seg", {1'b0, seg}, 8'h7F);
      chk("midrst_an", {6'd0, an}, 8'h03);
      chk("midrst_fs", {7'd0, frame_start}, 8'h00);
      reset = 1'b0;
      check_frame(7'h40, 7'h40, 2'b01, 0, 4'd0, 4'd0);
      check_frame(7'b0110000, 7'b1111000, 2'b01, 0, 4'd0, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
